// File: rtl/demultiplexor3_collect.sv
// Serial-to-parallel collector: routes single bits into 8 positions, either addressed by sel or
// by an internal pointer, and presents the word once every position has been written.
module demultiplexor3_collect #(
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic [2:0] sel,
  input  logic       mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] count
);

  typedef enum logic {StFill, StHold} state_e;

  state_e     state;
  logic [7:0] data;
  logic [7:0] mask;
  logic [2:0] ptr;

  logic [2:0] pos;
  logic [7:0] pos_oh;
  logic       accept;

  assign pos    = mode ? ptr : sel;
  assign pos_oh = 8'b1 << pos;
  assign accept = in_valid && in_ready && !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= StFill;
      data  <= 8'h00;
      mask  <= 8'h00;
      ptr   <= 3'd0;
    end else if (clear) begin
      // Abort wins over both an incoming beat and an output handoff.
      state <= StFill;
      mask  <= 8'h00;
      ptr   <= 3'd0;
      if (CLEAR_ON_POP) data <= 8'h00;
    end else begin
      unique case (state)
        StFill: begin
          if (accept) begin
            data[pos] <= in;
            mask      <= mask | pos_oh;
            if (mode) ptr <= ptr + 3'd1;
            if ((mask | pos_oh) == 8'hFF) state <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            state <= StFill;
            mask  <= 8'h00;
            ptr   <= 3'd0;
            if (CLEAR_ON_POP) data <= 8'h00;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + 4'(mask[i]);
    end
  end

  assign in_ready  = rst_n && (state == StFill);
  assign out_valid = (state == StHold);
  assign out       = data;

endmodule

// File: tb/tb_demultiplexor3_collect.sv
// Directed bench for demultiplexor3_collect: a scoreboard queue holds expected frames and a
// monitor pops one on every output handoff; status outputs are checked inline.
module tb_demultiplexor3_collect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in;
  logic [2:0] sel;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic       clear;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  demultiplexor3_collect #(.CLEAR_ON_POP(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sel      (sel),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, input logic [2:0] s, input logic b);
    mode     = m;
    sel      = s;
    in       = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every handoff must match the oldest expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_frame", {24'h0, out}, 32'hFFFF_FFFF);
        else chk("frame", {24'h0, out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bits;
    logic [2:0] sels[9];
    rst_n = 1'b0; in = 1'b0; sel = 3'd0; mode = 1'b0; in_valid = 1'b0;
    clear = 1'b0; out_ready = 1'b1;
    tick();
    chk("in_ready_in_reset", in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Sequential fill -> 8'h4D
    bits = 8'h4D;
    exp_q.push_back(8'h4D);
    for (int i = 0; i < 7; i++) beat(1'b1, 3'd0, bits[i]);
    chk("seq_count7", count, 7);
    chk("seq_not_valid", out_valid, 0);
    beat(1'b1, 3'd0, bits[7]);
    chk("seq_valid", out_valid, 1);
    chk("seq_out", out, 8'h4D);
    chk("seq_count8", count, 8);
    chk("seq_in_ready_hold", in_ready, 0);
    tick();
    chk("seq_pop_valid", out_valid, 0);
    chk("seq_pop_out", out, 8'h00);
    chk("seq_pop_count", count, 0);

    // Addressed fill with a rewrite of position 3
    sels = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    exp_q.push_back(8'hF7);
    for (int i = 0; i < 8; i++) beat(1'b0, sels[i], (i == 3) ? 1'b0 : 1'b1);
    chk("addr_count7", count, 7);
    chk("addr_not_valid", out_valid, 0);
    beat(1'b0, sels[8], 1'b1);
    chk("addr_valid", out_valid, 1);
    chk("addr_out", out, 8'hF7);
    tick();
    chk("addr_pop_valid", out_valid, 0);

    // Backpressure, including a beat offered during the handoff cycle
    out_ready = 1'b0;
    bits = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) beat(1'b1, 3'd0, bits[i]);
    mode = 1'b1; in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_stable", out, 8'hA5);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_pop_valid", out_valid, 0);
    chk("bp_pop_count", count, 0);
    chk("bp_pop_out", out, 8'h00);
    in_valid = 1'b0;

    // Wrap and mix: seq 0..4, addr 6, seq 5,6,7
    exp_q.push_back(8'h73);
    beat(1'b1, 3'd0, 1'b1);
    beat(1'b1, 3'd0, 1'b1);
    beat(1'b1, 3'd0, 1'b0);
    beat(1'b1, 3'd0, 1'b0);
    beat(1'b1, 3'd0, 1'b1);
    beat(1'b0, 3'd6, 1'b0);
    beat(1'b1, 3'd0, 1'b1);
    beat(1'b1, 3'd0, 1'b1);
    chk("mix_count7", count, 7);
    chk("mix_not_valid", out_valid, 0);
    beat(1'b1, 3'd0, 1'b0);
    chk("mix_valid", out_valid, 1);
    chk("mix_out", out, 8'h73);
    tick();

    // Abort at count=4 with a simultaneous beat
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd0, 1'b1);
    chk("abort_pre_count", count, 4);
    chk("abort_pre_out", out, 8'h0F);
    clear = 1'b1;
    beat(1'b1, 3'd0, 1'b1);
    clear = 1'b0;
    chk("abort_count", count, 0);
    chk("abort_out", out, 8'h00);
    chk("abort_valid", out_valid, 0);
    beat(1'b1, 3'd5, 1'b1);
    chk("abort_ptr_reset", out, 8'h01);
    chk("abort_after_count", count, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Reset while holding a complete frame
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(1'b1, 3'd0, 1'b1);
    chk("rsth_valid", out_valid, 1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rsth_out_valid", out_valid, 0);
    chk("rsth_out", out, 8'h00);
    chk("rsth_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rsth_in_ready", in_ready, 1);
    chk("rsth_count", count, 0);

    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demultiplexor3_collect.md
DEMULTIPLEXOR3_COLLECT -- requirements
Module: demultiplexor3_collect

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter CLEAR_ON_POP, default 1, meaning: 1 = the data register is zeroed on output handoff, 0 = the data register keeps its old contents.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 in  input  1  serial data bit to be routed to one of 8 output positions.
REQ-006 sel  input  3  destination index for in; used only when mode=0.
REQ-007 mode  input  1  0 = addressed (position taken from sel), 1 = sequential (position taken from internal pointer).
REQ-008 in_valid  input  1  in, sel and mode are valid this cycle.
REQ-009 in_ready  output  1  the block accepts a beat this cycle.
REQ-010 clear  input  1  synchronous frame abort.
REQ-011 out  output  8  assembled parallel word.
REQ-012 out_valid  output  1  out holds a complete frame.
REQ-013 out_ready  input  1  the consumer accepts out this cycle.
REQ-014 count  output  4  number of distinct positions filled in the current frame, 0..8.

Function
REQ-015 The FSM SHALL have two states. FILL: in_ready=1, out_valid=0. HOLD: in_ready=0, out_valid=1.
REQ-016 A beat is accepted on a rising edge with in_valid=1, in_ready=1 and clear=0.
REQ-017 Addressed beat (mode=0): data[sel] <= in; mask[sel] <= 1.
REQ-018 Sequential beat (mode=1): data[ptr] <= in; mask[ptr] <= 1; ptr <= ptr+1, wrapping from 7 to 0.
REQ-019 ptr SHALL NOT change on addressed beats; modes may be mixed within a frame.
REQ-020 Rewriting an already-filled position SHALL overwrite its data bit, leave mask unchanged, and leave count unchanged.
REQ-021 count SHALL equal the population count of mask; it is combinational from registered mask.
REQ-022 FILL->HOLD transition: on the edge where the accepted beat makes mask==8'hFF, out_valid=1 from the next cycle. Latency from the 8th distinct bit to out_valid is 1 cycle.
REQ-023 out SHALL equal the data register at all times and SHALL be stable while out_valid=1.
REQ-024 HOLD->FILL transition: on an edge with out_ready=1, mask<=0, ptr<=0, and data<=0 if CLEAR_ON_POP=1.
REQ-025 No bypass: in_ready=0 throughout HOLD, including the handoff cycle, so in_valid during that cycle SHALL NOT be accepted.
REQ-026 clear=1 in either state SHALL set state<=FILL, mask<=0 and ptr<=0, and set data<=0 if CLEAR_ON_POP=1; clear has priority over an input beat and over out handoff.
REQ-027 The 8-bit data, the mask and the 3-bit ptr SHALL stay within width; ptr wrap SHALL be silent.
REQ-028 in, sel and mode SHALL be don't-care when in_valid=0.

Reset
REQ-029 While rst_n=0 at a rising edge: state<=FILL, data<=8'h00, mask<=8'h00, ptr<=0.
REQ-030 Post-reset outputs SHALL be out=8'h00, out_valid=0, count=0, in_ready=1.
REQ-031 in_ready SHALL be forced to 0 while rst_n=0.
REQ-032 rst_n SHALL override clear, in_valid and out_ready.
REQ-033 Reset mid-frame or in HOLD SHALL discard the partial or complete frame with no out_valid pulse.

Verification
REQ-034 Sequential fill: mode=1, in bits 1,0,1,1,0,0,1,0 on 8 consecutive beats -> out=8'h4D, out_valid=1 one cycle after the 8th beat, count=8.
REQ-035 Addressed fill with rewrite: sel order 7,0,3,3,1,2,4,5,6 with in=1 except the second sel=3 beat in=0 -> count reaches 8 only on the 9th beat, out=8'hF7.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, out stable, no beat accepted; then out_ready=1 -> next cycle out_valid=0, count=0, out=8'h00 (CLEAR_ON_POP=1).
REQ-037 Wrap and mix: 5 sequential beats, 1 addressed beat with sel=6, 3 sequential beats writing positions 5,6,7 -> frame completes on the 9th beat; ptr wraps to 0 at completion.
REQ-038 Abort: clear=1 asserted together with in_valid=1 at count=4 -> next cycle count=0, out=8'h00, beat not stored.
REQ-039 Reset in HOLD: rst_n=0 for one edge while out_valid=1 -> next cycle out_valid=0, out=8'h00, in_ready=1.
